// File: rtl/sdram_ch1_linebuf_if.sv
// Bus bundles for the sdram channel 1 line buffer: CPU-facing side and controller-facing side.
// On each bus the master drives the request; the slave answers it.

interface sdram_ch1_linebuf_cpu_if;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [26:0] cpu_addr;
    logic        cpu_uncached;
    logic [15:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_done;
    logic        cpu_busy;
    logic        inval;

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_uncached, cpu_din, inval,
        input  cpu_dout, cpu_done, cpu_busy
    );
    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_uncached, cpu_din, inval,
        output cpu_dout, cpu_done, cpu_busy
    );
endinterface

interface sdram_ch1_linebuf_ch1_if;
    logic [26:0]  ch1_addr;
    logic [15:0]  ch1_din;
    logic         ch1_req;
    logic         ch1_rnw;
    logic         ch1_128;
    logic [127:0] ch1_dout;
    logic         ch1_ready;

    modport master (
        output ch1_addr, ch1_din, ch1_req, ch1_rnw, ch1_128,
        input  ch1_dout, ch1_ready
    );
    modport slave (
        input  ch1_addr, ch1_din, ch1_req, ch1_rnw, ch1_128,
        output ch1_dout, ch1_ready
    );
endinterface

// File: rtl/sdram_ch1_linebuf.sv
// CPU read line buffer and request sequencer in front of sdram channel 1.
// Cached reads fill 128-bit lines; writes are write-through; uncached reads go straight to ch1.

module sdram_ch1_linebuf #(
    parameter int NUM_LINES = 2,
    parameter int REQ_HOLD  = 2
) (
    input  logic                          clk1x,
    input  logic                          reset_n,
    sdram_ch1_linebuf_cpu_if.slave        cpu,
    sdram_ch1_linebuf_ch1_if.master       ch1
);

    localparam int PTR_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_W = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REQ_HOLD - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               rdy_q;
    logic               fill_inval_q, fill_inval_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [26:0]        addr_q, addr_d;
    logic [15:0]        din_q, din_d;
    logic               rnw_q, rnw_d;
    logic               unc_q, unc_d;

    logic [26:0]        ch1_addr_q, ch1_addr_d;
    logic [15:0]        ch1_din_q, ch1_din_d;
    logic               ch1_req_q, ch1_req_d;
    logic               ch1_rnw_q, ch1_rnw_d;
    logic               ch1_128_q, ch1_128_d;
    logic [31:0]        cpu_dout_q, cpu_dout_d;
    logic               cpu_done_q, cpu_done_d;
    logic               busy_q, busy_d;

    logic [127:0]       line_q [NUM_LINES];
    logic [22:0]        tag_q  [NUM_LINES];
    logic               line_we, tag_we;
    logic [PTR_W-1:0]   line_widx;
    logic [127:0]       line_wdata;

    logic               rd_hit, wr_hit;
    logic [PTR_W-1:0]   rd_idx, wr_idx;
    logic               unused_addr_bit;

    function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] idx);
        sel_word = line[{idx, 5'b00000} +: 32];
    endfunction

    function automatic logic [127:0] merge_half(input logic [127:0] line, input logic [2:0] idx,
                                                input logic [15:0] half);
        logic [127:0] res;
        res = line;
        res[{idx, 4'b0000} +: 16] = half;
        merge_half = res;
    endfunction

    // Tag lookup: rd_* serves an incoming CPU read, wr_* the latched write at CAPTURE.
    always_comb begin
        rd_hit = 1'b0;
        rd_idx = '0;
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == cpu.cpu_addr[26:4])) begin
                rd_hit = 1'b1;
                rd_idx = PTR_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == addr_q[26:4])) begin
                wr_hit = 1'b1;
                wr_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        valid_d      = valid_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rnw_d        = rnw_q;
        unc_d        = unc_q;
        ch1_addr_d   = ch1_addr_q;
        ch1_din_d    = ch1_din_q;
        ch1_req_d    = ch1_req_q;
        ch1_rnw_d    = ch1_rnw_q;
        ch1_128_d    = ch1_128_q;
        cpu_dout_d   = cpu_dout_q;
        cpu_done_d   = 1'b0;
        busy_d       = busy_q;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_widx    = ptr_q;
        line_wdata   = ch1.ch1_dout;
        // An invalidate seen while a request is outstanding must keep that fill from becoming valid.
        fill_inval_d = fill_inval_q | (cpu.inval && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (cpu.cpu_req) begin
                    if (cpu.cpu_rnw && !cpu.cpu_uncached && rd_hit) begin
                        cpu_done_d = 1'b1;
                        cpu_dout_d = sel_word(line_q[rd_idx], cpu.cpu_addr[3:2]);
                    end else begin
                        addr_d       = cpu.cpu_addr;
                        din_d        = cpu.cpu_din;
                        rnw_d        = cpu.cpu_rnw;
                        unc_d        = cpu.cpu_uncached;
                        busy_d       = 1'b1;
                        ch1_req_d    = 1'b1;
                        hold_d       = '0;
                        fill_inval_d = 1'b0;
                        ch1_rnw_d    = cpu.cpu_rnw;
                        ch1_128_d    = cpu.cpu_rnw & ~cpu.cpu_uncached;
                        if (!cpu.cpu_rnw) begin
                            ch1_addr_d = {cpu.cpu_addr[26:1], 1'b0};
                            ch1_din_d  = cpu.cpu_din;
                        end else if (cpu.cpu_uncached) begin
                            ch1_addr_d = {cpu.cpu_addr[26:2], 2'b00};
                        end else begin
                            ch1_addr_d = {cpu.cpu_addr[26:4], 4'h0};
                        end
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (hold_q == HOLD_LAST) begin
                    ch1_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT: begin
                if (ch1.ch1_ready && !rdy_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Burst tail lands after the ready pulse, so ch1_dout is sampled here, one cycle later.
                cpu_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
                if (rnw_q && !unc_q) begin
                    line_we        = 1'b1;
                    tag_we         = 1'b1;
                    line_widx      = ptr_q;
                    line_wdata     = ch1.ch1_dout;
                    valid_d[ptr_q] = ~(fill_inval_q | cpu.inval);
                    ptr_d          = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
                    cpu_dout_d     = sel_word(ch1.ch1_dout, addr_q[3:2]);
                end else if (rnw_q) begin
                    cpu_dout_d = ch1.ch1_dout[31:0];
                end else if (wr_hit) begin
                    line_we    = 1'b1;
                    line_widx  = wr_idx;
                    line_wdata = merge_half(line_q[wr_idx], addr_q[3:1], din_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (cpu.inval) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            rdy_q        <= 1'b0;
            fill_inval_q <= 1'b0;
            valid_q      <= '0;
            ptr_q        <= '0;
            ch1_addr_q   <= '0;
            ch1_din_q    <= '0;
            ch1_req_q    <= 1'b0;
            ch1_rnw_q    <= 1'b0;
            ch1_128_q    <= 1'b0;
            cpu_dout_q   <= '0;
            cpu_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rdy_q        <= ch1.ch1_ready;
            fill_inval_q <= fill_inval_d;
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            ch1_addr_q   <= ch1_addr_d;
            ch1_din_q    <= ch1_din_d;
            ch1_req_q    <= ch1_req_d;
            ch1_rnw_q    <= ch1_rnw_d;
            ch1_128_q    <= ch1_128_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_done_q   <= cpu_done_d;
            busy_q       <= busy_d;
        end
    end

    // Line storage and latched request fields carry no reset; valid bits and state guard them.
    always_ff @(posedge clk1x) begin
        addr_q <= addr_d;
        din_q  <= din_d;
        rnw_q  <= rnw_d;
        unc_q  <= unc_d;
        if (line_we) begin
            line_q[line_widx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[line_widx] <= addr_q[26:4];
        end
    end

    assign unused_addr_bit = addr_q[0];

    assign cpu.cpu_dout = cpu_dout_q;
    assign cpu.cpu_done = cpu_done_q;
    assign cpu.cpu_busy = busy_q;
    assign ch1.ch1_addr = ch1_addr_q;
    assign ch1.ch1_din  = ch1_din_q;
    assign ch1.ch1_req  = ch1_req_q;
    assign ch1.ch1_rnw  = ch1_rnw_q;
    assign ch1.ch1_128  = ch1_128_q;

endmodule

// File: tb/tb_sdram_ch1_linebuf.sv
// Directed bench for sdram_ch1_linebuf: a table of CPU transactions against a small ch1 responder,
// plus hand-written sequences for reset behaviour and a late ready after reset.

module tb_sdram_ch1_linebuf;

    localparam int NUM_LINES = 2;
    localparam int REQ_HOLD  = 2;

    localparam logic [127:0] L1 = 128'hAAAABBBB_CCCCDDDD_11112222_55556666;
    localparam logic [127:0] L2 = 128'h13131313_12121212_11111111_10101010;
    localparam logic [127:0] L3 = 128'h23232323_22222222_21212121_20202020;
    localparam logic [127:0] L4 = 128'h99999999_88888888_77777777_CAFEF00D;
    localparam logic [127:0] L5 = 128'h33333333_32323232_31313131_30003000;
    localparam logic [127:0] L6 = 128'h63636363_62626262_61616161_60606060;

    typedef struct {
        logic         rnw;
        logic         unc;
        logic [26:0]  addr;
        logic [15:0]  din;
        logic         miss;   // a ch1 request is expected
        logic [26:0]  eaddr;
        logic         e128;
        logic [127:0] line;   // data the responder returns
        logic [31:0]  edout;
        int           inv;    // 0 none, 1 with cpu_req, 2 while in flight
        logic         poke;   // extra cpu_req while busy
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sdram_ch1_linebuf_cpu_if cpu_bus ();
    sdram_ch1_linebuf_ch1_if ch1_bus ();

    sdram_ch1_linebuf #(
        .NUM_LINES(NUM_LINES),
        .REQ_HOLD (REQ_HOLD)
    ) dut (
        .clk1x  (clk),
        .reset_n(rst_n),
        .cpu    (cpu_bus.slave),
        .ch1    (ch1_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ch1_req"},  128'(ch1_bus.ch1_req),  128'h0);
        chk({tag, "_ch1_addr"}, 128'(ch1_bus.ch1_addr), 128'h0);
        chk({tag, "_ch1_din"},  128'(ch1_bus.ch1_din),  128'h0);
        chk({tag, "_ch1_rnw"},  128'(ch1_bus.ch1_rnw),  128'h0);
        chk({tag, "_ch1_128"},  128'(ch1_bus.ch1_128),  128'h0);
        chk({tag, "_cpu_dout"}, 128'(cpu_bus.cpu_dout), 128'h0);
        chk({tag, "_cpu_done"}, 128'(cpu_bus.cpu_done), 128'h0);
        chk({tag, "_cpu_busy"}, 128'(cpu_bus.cpu_busy), 128'h0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_txn(input vec_t v, input int n);
        int   cyc;
        int   reqs;
        int   hold;
        int   resp;
        logic prev_req;
        logic done;
        string tg;
        tg = $sformatf("v%0d", n);
        cpu_bus.cpu_rnw      = v.rnw;
        cpu_bus.cpu_uncached = v.unc;
        cpu_bus.cpu_addr     = v.addr;
        cpu_bus.cpu_din      = v.din;
        cpu_bus.cpu_req      = 1'b1;
        cpu_bus.inval        = (v.inv == 1);
        @(posedge clk); #1;
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.inval   = 1'b0;
        cyc = 1; reqs = 0; hold = 0; resp = 0; prev_req = 1'b0; done = 1'b0;
        while (!done && cyc < 100) begin
            if (cyc == 1) chk({tg, "_busy"}, 128'(cpu_bus.cpu_busy), 128'(v.miss));
            if (cpu_bus.cpu_done) begin
                done = 1'b1;
            end else begin
                if (ch1_bus.ch1_req && !prev_req) begin
                    reqs++;
                    chk({tg, "_ch1_addr"}, 128'(ch1_bus.ch1_addr), 128'(v.eaddr));
                    chk({tg, "_ch1_rnw"},  128'(ch1_bus.ch1_rnw),  128'(v.rnw));
                    chk({tg, "_ch1_128"},  128'(ch1_bus.ch1_128),  128'(v.e128));
                    if (!v.rnw) chk({tg, "_ch1_din"}, 128'(ch1_bus.ch1_din), 128'(v.din));
                end
                if (ch1_bus.ch1_req) hold++;
                if (prev_req && !ch1_bus.ch1_req) resp = 1;
                prev_req = ch1_bus.ch1_req;
                // Ready pulse carries stale data; the full line is only valid the cycle after.
                if (resp == 2) begin
                    ch1_bus.ch1_ready = 1'b1;
                    ch1_bus.ch1_dout  = ~v.line;
                end else if (resp == 3) begin
                    ch1_bus.ch1_ready = 1'b1;
                    ch1_bus.ch1_dout  = v.line;
                end else begin
                    ch1_bus.ch1_ready = 1'b0;
                end
                if (resp > 0) resp++;
                cpu_bus.inval = (v.inv == 2 && cyc == 2);
                if (v.poke && cyc == 3) begin
                    cpu_bus.cpu_req  = 1'b1;
                    cpu_bus.cpu_addr = 27'h0007000;
                end else begin
                    cpu_bus.cpu_req = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        ch1_bus.ch1_ready = 1'b0;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.inval     = 1'b0;
        chk({tg, "_done_seen"}, 128'(done), 128'h1);
        chk({tg, "_req_count"}, 128'(reqs), 128'(v.miss ? 1 : 0));
        if (v.miss) chk({tg, "_req_hold"}, 128'(hold), 128'(REQ_HOLD));
        else        chk({tg, "_hit_latency"}, 128'(cyc), 128'h1);
        if (v.rnw)  chk({tg, "_dout"}, 128'(cpu_bus.cpu_dout), 128'(v.edout));
        @(posedge clk); #1;
        chk({tg, "_done_pulse"}, 128'(cpu_bus.cpu_done), 128'h0);
        chk({tg, "_no_extra_req"}, 128'(ch1_bus.ch1_req), 128'h0);
    endtask

    vec_t tbl [17];
    vec_t extra;
    int   seen;
    int   dones;

    initial begin
        checks   = 0;
        failures = 0;
        //             rnw   unc   addr         din      miss  eaddr        e128  line  edout          inv poke
        tbl[0]  = '{1'b1, 1'b0, 27'h0000014, 16'h0000, 1'b1, 27'h0000010, 1'b1, L1, 32'h11112222, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 27'h000001C, 16'h0000, 1'b0, 27'h0000000, 1'b0, L1, 32'hAAAABBBB, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 27'h0000016, 16'hBEEF, 1'b1, 27'h0000016, 1'b0, L1, 32'h00000000, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 27'h0000014, 16'h0000, 1'b0, 27'h0000000, 1'b0, L1, 32'hBEEF2222, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 27'h040000B, 16'h0000, 1'b1, 27'h0400008, 1'b0, L4, 32'hCAFEF00D, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 27'h0000014, 16'h0000, 1'b0, 27'h0000000, 1'b0, L1, 32'hBEEF2222, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 27'h0000100, 16'h0000, 1'b1, 27'h0000100, 1'b1, L2, 32'h10101010, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 27'h0000200, 16'h0000, 1'b1, 27'h0000200, 1'b1, L3, 32'h20202020, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 27'h0000104, 16'h0000, 1'b0, 27'h0000000, 1'b0, L2, 32'h11111111, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 27'h0000014, 16'h0000, 1'b1, 27'h0000010, 1'b1, L1, 32'h11112222, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 27'h0000208, 16'h0000, 1'b0, 27'h0000000, 1'b0, L3, 32'h22222222, 0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 27'h0003003, 16'h1234, 1'b1, 27'h0003002, 1'b0, L5, 32'h00000000, 0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 27'h0003000, 16'h0000, 1'b1, 27'h0003000, 1'b1, L5, 32'h30003000, 0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 27'h0003004, 16'h0000, 1'b0, 27'h0000000, 1'b0, L5, 32'h31313131, 1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 27'h0003008, 16'h0000, 1'b1, 27'h0003000, 1'b1, L5, 32'h32323232, 2, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 27'h000300C, 16'h0000, 1'b1, 27'h0003000, 1'b1, L5, 32'h33333333, 0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 27'h000300C, 16'h0000, 1'b0, 27'h0000000, 1'b0, L5, 32'h33333333, 0, 1'b0};

        rst_n                = 1'b0;
        cpu_bus.cpu_req      = 1'b0;
        cpu_bus.cpu_rnw      = 1'b0;
        cpu_bus.cpu_addr     = '0;
        cpu_bus.cpu_uncached = 1'b0;
        cpu_bus.cpu_din      = '0;
        cpu_bus.inval        = 1'b0;
        ch1_bus.ch1_dout     = '0;
        ch1_bus.ch1_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_outputs_zero("reset");

        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i], i);
        end

        // Reset while waiting on the controller, then a late ready that must be ignored.
        cpu_bus.cpu_rnw      = 1'b1;
        cpu_bus.cpu_uncached = 1'b0;
        cpu_bus.cpu_addr     = 27'h0006004;
        cpu_bus.cpu_req      = 1'b1;
        @(posedge clk); #1;
        cpu_bus.cpu_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            if (ch1_bus.ch1_req) seen = 1;
            else if (seen == 1) seen = 2;
            if (seen < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_wait_reached", 128'(seen), 128'h2);
        rst_n = 1'b0;
        #2;
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ch1_bus.ch1_dout  = L6;
        ch1_bus.ch1_ready = 1'b1;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) ch1_bus.ch1_ready = 1'b0;
            @(posedge clk); #1;
            if (cpu_bus.cpu_done) dones++;
        end
        chk("late_ready_no_done", 128'(dones), 128'h0);
        chk("late_ready_not_busy", 128'(cpu_bus.cpu_busy), 128'h0);

        extra = '{1'b1, 1'b0, 27'h0006004, 16'h0000, 1'b1, 27'h0006000, 1'b1, L6, 32'h61616161, 0, 1'b0};
        run_txn(extra, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
